// File: rtl/alu_sequencer.sv
// alu_sequencer: executes one ALU-class CHIP-8 instruction (3xkk, 4xkk, 5xy0,
// 7xkk, 9xy0, 8xyN, Fx1E). Reads Vx/Vy/I, drives the shared ALU, holds its
// operands stable until the ALU reports done, then writes result/VF/I back
// and reports skip. The ALU is held in reset outside EXEC so it starts clean.
// Compile-time option: VF_RESET_QUIRK_EN -- logic ops 8xy1/8xy2/8xy3 also
// write VF=0 (original COSMAC VIP behaviour). Undefined: VF untouched by them.
package alu_seq_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_AND  = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SHR  = 4'd5,
    ALU_SHL  = 4'd6,
    ALU_SE   = 4'd7,
    ALU_SNE  = 4'd8,
    ALU_ADDL = 4'd9
  } alu_op_e;

  typedef struct packed {
    alu_op_e     op;
    logic [7:0]  operand_a;
    logic [7:0]  operand_b;
    logic [15:0] operand_b_long;
  } alu_input;
endpackage

module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [3:0]  vx_addr,
  output logic [3:0]  vy_addr,
  input  logic [7:0]  vx_data,
  input  logic [7:0]  vy_data,
  input  logic [15:0] i_data,
  output logic        reg_we,
  output logic [3:0]  reg_waddr,
  output logic [7:0]  reg_wdata,
  output logic        i_we,
  output logic [15:0] i_wdata,
  output logic        alu_rst,
  output alu_input    alu_in,
  input  logic [7:0]  alu_result,
  input  logic [15:0] alu_result_long,
  input  logic        alu_overflow,
  input  logic        alu_done,
  output logic        done,
  output logic        skip,
  output logic        err
);
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_EXEC, S_WB_RES, S_WB_FLAG, S_FINISH
  } state_e;

  state_e          state, state_next;
  logic [15:0]     instr_p0;
  logic [7:0]      res_p1;
  logic [15:0]     res_long_p1;
  logic            ovf_p1;
  logic            err_p0;
  logic [WD_W-1:0] wdog;
  logic            wdog_expire;
  alu_input        alu_next;

  logic [3:0] opc, fn;
  logic       is_skip, wr_reg, wr_i, wr_flag, flag_bit;

  assign opc         = instr_p0[15:12];
  assign fn          = instr_p0[3:0];
  assign wdog_expire = (wdog == WD_LAST);

  function automatic logic is_legal(input logic [15:0] op);
    logic ok;
    case (op[15:12])
      4'h3, 4'h4, 4'h7: ok = 1'b1;
      4'h5, 4'h9:       ok = (op[3:0] == 4'h0);
      4'h8:             ok = op[3:0] inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hE};
      4'hF:             ok = (op[7:0] == 8'h1E);
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Classify the latched opcode into writeback / skip behaviour
  always_comb begin
    is_skip = opc inside {4'h3, 4'h4, 4'h5, 4'h9};
    wr_reg  = (opc == 4'h7) || (opc == 4'h8);
    wr_i    = (opc == 4'hF);
`ifdef VF_RESET_QUIRK_EN
    wr_flag  = (opc == 4'h8) && (fn inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hE});
    flag_bit = ovf_p1 & ~(fn inside {4'h1, 4'h2, 4'h3});
`else
    wr_flag  = (opc == 4'h8) && (fn inside {4'h4, 4'h5, 4'h6, 4'h7, 4'hE});
    flag_bit = ovf_p1;
`endif
  end

  // Build the ALU request from the register-file read data during READ
  always_comb begin
    alu_next                = '{op: ALU_ADD, default: '0};
    alu_next.operand_a      = vx_data;
    alu_next.operand_b      = vy_data;
    case (opc)
      4'h3: begin alu_next.op = ALU_SE;  alu_next.operand_b = instr_p0[7:0]; end
      4'h4: begin alu_next.op = ALU_SNE; alu_next.operand_b = instr_p0[7:0]; end
      4'h5: alu_next.op = ALU_SE;
      4'h9: alu_next.op = ALU_SNE;
      4'h7: begin alu_next.op = ALU_ADD; alu_next.operand_b = instr_p0[7:0]; end
      4'h8: begin
        case (fn)
          4'h1: alu_next.op = ALU_OR;
          4'h2: alu_next.op = ALU_AND;
          4'h3: alu_next.op = ALU_XOR;
          4'h4: alu_next.op = ALU_ADD;
          4'h5: alu_next.op = ALU_SUB;
          4'h7: begin
            alu_next.op        = ALU_SUB;
            alu_next.operand_a = vy_data;
            alu_next.operand_b = vx_data;
          end
          4'h6: begin alu_next.op = ALU_SHR; alu_next.operand_b = 8'h01; end
          4'hE: begin alu_next.op = ALU_SHL; alu_next.operand_b = 8'h01; end
          default: alu_next.op = ALU_ADD;
        endcase
      end
      4'hF: begin
        alu_next.op             = ALU_ADDL;
        alu_next.operand_b_long = i_data & 16'h0FFF;
      end
      default: alu_next.op = ALU_ADD;
    endcase
  end

  // State register, error flag, watchdog and the held ALU request
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state  <= S_IDLE;
      err_p0 <= 1'b0;
      wdog   <= '0;
      alu_in <= '{op: ALU_ADD, default: '0};
    end else begin
      state <= state_next;
      wdog  <= (state == S_EXEC) ? wdog + 1'b1 : '0;
      if (state == S_IDLE && instr_valid)
        err_p0 <= ~is_legal(instr);
      else if (state == S_EXEC && !alu_done && wdog_expire)
        err_p0 <= 1'b1;
      if (state == S_READ)
        alu_in <= alu_next;
    end
  end

  // Latched instruction and captured ALU results (data path, no reset)
  always_ff @(posedge clk_in) begin
    if (state == S_IDLE && instr_valid)
      instr_p0 <= instr;
    if (state == S_EXEC && alu_done) begin
      res_p1      <= alu_result;
      res_long_p1 <= alu_result_long;
      ovf_p1      <= alu_overflow;
    end
  end

  // Next-state logic; writeback states are bypassed when not needed
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (instr_valid) state_next = is_legal(instr) ? S_READ : S_FINISH;
      S_READ:    state_next = S_EXEC;
      S_EXEC: begin
        if (alu_done)
          state_next = (wr_reg || wr_i) ? S_WB_RES : (wr_flag ? S_WB_FLAG : S_FINISH);
        else if (wdog_expire)
          state_next = S_FINISH;
      end
      S_WB_RES:  state_next = wr_flag ? S_WB_FLAG : S_FINISH;
      S_WB_FLAG: state_next = S_FINISH;
      S_FINISH:  state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state; strobes last exactly one cycle
  always_comb begin
    instr_ready = (state == S_IDLE);
    alu_rst     = (state != S_EXEC);
    vx_addr     = 4'h0;
    vy_addr     = 4'h0;
    reg_we      = 1'b0;
    reg_waddr   = 4'h0;
    reg_wdata   = 8'h00;
    i_we        = 1'b0;
    i_wdata     = 16'h0000;
    done        = 1'b0;
    skip        = 1'b0;
    err         = 1'b0;
    case (state)
      S_READ: begin
        vx_addr = instr_p0[11:8];
        vy_addr = instr_p0[7:4];
      end
      S_WB_RES: begin
        if (wr_i) begin
          i_we    = 1'b1;
          i_wdata = res_long_p1;
        end else begin
          reg_we    = 1'b1;
          reg_waddr = instr_p0[11:8];
          reg_wdata = res_p1;
        end
      end
      S_WB_FLAG: begin
        reg_we    = 1'b1;
        reg_waddr = 4'hF;
        reg_wdata = {7'b0, flag_bit};
      end
      S_FINISH: begin
        done = 1'b1;
        err  = err_p0;
        skip = is_skip & ~err_p0 & res_p1[0];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vector table plus hand sequences for reset
// during EXEC. The bench provides the register file, I register and a
// behavioural ALU with programmable latency (or a stuck done).
`timescale 1ns/1ps
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  xv, yv, vfv;
    logic [15:0] iv;
    int          lat;
    logic        stuck;
    logic        eskip, eerr;
    int          enreg, eni, eexec;
    logic [7:0]  evx, evf;
    logic [15:0] ei;
  } vec_t;

  localparam int NV = 20;
`ifdef VF_RESET_QUIRK_EN
  localparam int         QN  = 2;
  localparam logic [7:0] QVF = 8'h00;
`else
  localparam int         QN  = 1;
  localparam logic [7:0] QVF = 8'h55;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [3:0]  vx_addr, vy_addr;
  logic [7:0]  vx_data, vy_data;
  logic [15:0] i_data;
  logic        reg_we;
  logic [3:0]  reg_waddr;
  logic [7:0]  reg_wdata;
  logic        i_we;
  logic [15:0] i_wdata;
  logic        alu_rst;
  alu_input    alu_in;
  logic [7:0]  alu_result;
  logic [15:0] alu_result_long;
  logic        alu_overflow;
  logic        alu_done;
  logic        done, skip, err;

  logic [7:0]  regs [16];
  logic [15:0] ireg;
  int          lat;
  logic        stuck;
  int          checks = 0, failures = 0;
  int          nreg, ni, nexec, ndone, nboth, nstray, nchg;
  logic        seen_skip, seen_err, prev_exec;
  alu_input    prev_alu;
  vec_t        vecs [NV];

  always #5 clk_in = ~clk_in;

  assign vx_data = regs[vx_addr];
  assign vy_data = regs[vy_addr];
  assign i_data  = ireg;

  alu_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .vx_addr(vx_addr), .vy_addr(vy_addr),
    .vx_data(vx_data), .vy_data(vy_data), .i_data(i_data),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .i_we(i_we), .i_wdata(i_wdata), .alu_rst(alu_rst), .alu_in(alu_in),
    .alu_result(alu_result), .alu_result_long(alu_result_long),
    .alu_overflow(alu_overflow), .alu_done(alu_done),
    .done(done), .skip(skip), .err(err)
  );

  // Behavioural ALU: done rises a programmable number of cycles after release
  int   acnt;
  logic adone;
  always @(posedge clk_in) begin
    if (alu_rst) begin
      acnt  <= 0;
      adone <= 1'b0;
    end else begin
      acnt  <= acnt + 1;
      adone <= !stuck && (acnt + 1 >= lat);
    end
  end
  assign alu_done = adone;

  // Combinational ALU function on the held request
  logic [8:0] sum9;
  always_comb begin
    alu_result      = 8'h00;
    alu_result_long = 16'h0000;
    alu_overflow    = 1'b0;
    sum9            = 9'h000;
    case (alu_in.op)
      ALU_ADD: begin
        sum9         = {1'b0, alu_in.operand_a} + {1'b0, alu_in.operand_b};
        alu_result   = sum9[7:0];
        alu_overflow = sum9[8];
      end
      ALU_SUB: begin
        alu_result   = alu_in.operand_a - alu_in.operand_b;
        alu_overflow = (alu_in.operand_a >= alu_in.operand_b);
      end
      ALU_OR:  alu_result = alu_in.operand_a | alu_in.operand_b;
      ALU_AND: alu_result = alu_in.operand_a & alu_in.operand_b;
      ALU_XOR: alu_result = alu_in.operand_a ^ alu_in.operand_b;
      ALU_SHR: begin alu_result = alu_in.operand_a >> 1; alu_overflow = alu_in.operand_a[0]; end
      ALU_SHL: begin alu_result = alu_in.operand_a << 1; alu_overflow = alu_in.operand_a[7]; end
      ALU_SE:  alu_result = {7'b0, alu_in.operand_a == alu_in.operand_b};
      ALU_SNE: alu_result = {7'b0, alu_in.operand_a != alu_in.operand_b};
      ALU_ADDL: alu_result_long = {8'h00, alu_in.operand_a} + alu_in.operand_b_long;
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    nreg = 0; ni = 0; nexec = 0; ndone = 0; nboth = 0; nstray = 0; nchg = 0;
    seen_skip = 1'b0; seen_err = 1'b0; prev_exec = 1'b0;
  endtask

  // Advance one cycle, sample at the falling edge and apply register writes
  task automatic cycle();
    @(negedge clk_in);
    if (reg_we && i_we) nboth++;
    if (reg_we) begin nreg++; regs[reg_waddr] = reg_wdata; end
    if (i_we) begin ni++; ireg = i_wdata; end
    if (!alu_rst) begin
      nexec++;
      if (prev_exec && alu_in != prev_alu) nchg++;
    end
    prev_exec = !alu_rst;
    prev_alu  = alu_in;
    if (done) begin ndone++; seen_skip = skip; seen_err = err; end
    else if (skip || err) nstray++;
  endtask

  function automatic vec_t mk(input logic [15:0] in_i, input logic [7:0] xv, input logic [7:0] yv,
                              input logic [7:0] vfv, input logic [15:0] iv, input int l,
                              input logic st, input logic es, input logic ee, input int enr,
                              input int eni, input int eex, input logic [7:0] evx,
                              input logic [7:0] evf, input logic [15:0] ei);
    vec_t v;
    v.instr = in_i; v.xv = xv; v.yv = yv; v.vfv = vfv; v.iv = iv; v.lat = l; v.stuck = st;
    v.eskip = es; v.eerr = ee; v.enreg = enr; v.eni = eni; v.eexec = eex;
    v.evx = evx; v.evf = evf; v.ei = ei;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    logic [3:0] xa, ya;
    int guard;
    xa = v.instr[11:8];
    ya = v.instr[7:4];
    for (int r = 0; r < 16; r++) regs[r] = 8'h00;
    regs[15] = v.vfv;
    regs[xa] = v.xv;
    regs[ya] = v.yv;
    ireg  = v.iv;
    lat   = v.lat;
    stuck = v.stuck;
    clear_counts();
    instr       = v.instr;
    instr_valid = 1'b1;
    cycle();
    instr = 16'h0000;
    cycle();
    instr_valid = 1'b0;
    guard = 0;
    while (ndone == 0 && guard < 64) begin
      cycle();
      guard++;
    end
    cycle();
    cycle();
    chk($sformatf("v%0d_%h_done", idx, v.instr), ndone, 1);
    chk($sformatf("v%0d_%h_skip", idx, v.instr), 32'(seen_skip), 32'(v.eskip));
    chk($sformatf("v%0d_%h_err", idx, v.instr), 32'(seen_err), 32'(v.eerr));
    chk($sformatf("v%0d_%h_nreg", idx, v.instr), nreg, v.enreg);
    chk($sformatf("v%0d_%h_ni", idx, v.instr), ni, v.eni);
    chk($sformatf("v%0d_%h_exec", idx, v.instr), nexec, v.eexec);
    chk($sformatf("v%0d_%h_vx", idx, v.instr), 32'(regs[xa]), 32'(v.evx));
    chk($sformatf("v%0d_%h_vf", idx, v.instr), 32'(regs[15]), 32'(v.evf));
    chk($sformatf("v%0d_%h_i", idx, v.instr), 32'(ireg), 32'(v.ei));
    chk($sformatf("v%0d_%h_both", idx, v.instr), nboth, 0);
    chk($sformatf("v%0d_%h_stray", idx, v.instr), nstray, 0);
    chk($sformatf("v%0d_%h_hold", idx, v.instr), nchg, 0);
  endtask

  initial begin
    //          instr     xv     yv     vfv    iv        lat st skp err nreg ni exec vx     vf     I
    vecs[0]  = mk(16'h8124, 8'hF0, 8'h20, 8'h55, 16'h0123, 2, 0, 0, 0, 2,  0, 3,  8'h10, 8'h01, 16'h0123);
    vecs[1]  = mk(16'h8345, 8'h10, 8'h20, 8'h55, 16'h0123, 1, 0, 0, 0, 2,  0, 2,  8'hF0, 8'h00, 16'h0123);
    vecs[2]  = mk(16'h8347, 8'h10, 8'h20, 8'h55, 16'h0123, 1, 0, 0, 0, 2,  0, 2,  8'h10, 8'h01, 16'h0123);
    vecs[3]  = mk(16'h3A42, 8'h42, 8'h00, 8'h55, 16'h0123, 1, 0, 1, 0, 0,  0, 2,  8'h42, 8'h55, 16'h0123);
    vecs[4]  = mk(16'h3A43, 8'h42, 8'h00, 8'h55, 16'h0123, 1, 0, 0, 0, 0,  0, 2,  8'h42, 8'h55, 16'h0123);
    vecs[5]  = mk(16'h9AB0, 8'h42, 8'h43, 8'h55, 16'h0123, 3, 0, 1, 0, 0,  0, 4,  8'h42, 8'h55, 16'h0123);
    vecs[6]  = mk(16'h5AB0, 8'h42, 8'h42, 8'h55, 16'h0123, 1, 0, 1, 0, 0,  0, 2,  8'h42, 8'h55, 16'h0123);
    vecs[7]  = mk(16'h4A42, 8'h42, 8'h00, 8'h55, 16'h0123, 1, 0, 0, 0, 0,  0, 2,  8'h42, 8'h55, 16'h0123);
    vecs[8]  = mk(16'hF01E, 8'h01, 8'h00, 8'h55, 16'h0FFF, 2, 0, 0, 0, 0,  1, 3,  8'h01, 8'h55, 16'h1000);
    vecs[9]  = mk(16'h8FE4, 8'hFF, 8'h01, 8'h55, 16'h0123, 1, 0, 0, 0, 2,  0, 2,  8'h01, 8'h01, 16'h0123);
    vecs[10] = mk(16'h8012, 8'h0F, 8'h3C, 8'h55, 16'h0123, 1, 0, 0, 0, QN, 0, 2,  8'h0C, QVF,   16'h0123);
    vecs[11] = mk(16'h7A05, 8'hFF, 8'h00, 8'h55, 16'h0123, 1, 0, 0, 0, 1,  0, 2,  8'h04, 8'h55, 16'h0123);
    vecs[12] = mk(16'h8016, 8'h81, 8'h00, 8'h55, 16'h0123, 1, 0, 0, 0, 2,  0, 2,  8'h40, 8'h01, 16'h0123);
    vecs[13] = mk(16'h801E, 8'h81, 8'h00, 8'h55, 16'h0123, 1, 0, 0, 0, 2,  0, 2,  8'h02, 8'h01, 16'h0123);
    vecs[14] = mk(16'h8011, 8'hF0, 8'h0F, 8'h55, 16'h0123, 1, 0, 0, 0, QN, 0, 2,  8'hFF, QVF,   16'h0123);
    vecs[15] = mk(16'h8013, 8'hF0, 8'hFF, 8'h55, 16'h0123, 1, 0, 0, 0, QN, 0, 2,  8'h0F, QVF,   16'h0123);
    vecs[16] = mk(16'h8125, 8'h20, 8'h20, 8'h55, 16'h0123, 1, 0, 0, 0, 2,  0, 2,  8'h00, 8'h01, 16'h0123);
    vecs[17] = mk(16'h8008, 8'h11, 8'h11, 8'h55, 16'h0123, 1, 0, 0, 1, 0,  0, 0,  8'h11, 8'h55, 16'h0123);
    vecs[18] = mk(16'h5AB1, 8'h42, 8'h42, 8'h55, 16'h0123, 1, 0, 0, 1, 0,  0, 0,  8'h42, 8'h55, 16'h0123);
    vecs[19] = mk(16'h8124, 8'hF0, 8'h20, 8'h55, 16'h0123, 1, 1, 0, 1, 0,  0, 16, 8'hF0, 8'h55, 16'h0123);

    for (int r = 0; r < 16; r++) regs[r] = 8'h00;
    ireg        = 16'h0000;
    lat         = 1;
    stuck       = 1'b0;
    instr       = 16'h0000;
    instr_valid = 1'b0;
    rst_in      = 1'b1;
    clear_counts();
    cycle();
    cycle();

    // Reset state
    chk("rst_ready", 32'(instr_ready), 1);
    chk("rst_alu_rst", 32'(alu_rst), 1);
    chk("rst_reg_we", 32'(reg_we), 0);
    chk("rst_i_we", 32'(i_we), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_skip", 32'(skip), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_alu_op", 32'(alu_in.op), 32'(ALU_ADD));
    chk("rst_alu_a", 32'(alu_in.operand_a), 0);
    rst_in = 1'b0;
    cycle();

    for (int k = 0; k < NV; k++) run_vec(vecs[k], k);

    // Reset while waiting in EXEC: back to IDLE, nothing written
    for (int r = 0; r < 16; r++) regs[r] = 8'h00;
    regs[1] = 8'hF0;
    regs[2] = 8'h20;
    stuck   = 1'b1;
    clear_counts();
    instr       = 16'h8124;
    instr_valid = 1'b1;
    cycle();
    instr_valid = 1'b0;
    cycle();
    cycle();
    chk("mid_in_exec", 32'(alu_rst), 0);
    rst_in = 1'b1;
    cycle();
    rst_in = 1'b0;
    chk("mid_ready", 32'(instr_ready), 1);
    chk("mid_alu_rst", 32'(alu_rst), 1);
    for (int c = 0; c < 6; c++) cycle();
    chk("mid_nreg", nreg, 0);
    chk("mid_ni", ni, 0);
    chk("mid_ndone", ndone, 0);
    chk("mid_v1", 32'(regs[1]), 32'h0000_00F0);
    stuck = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
